// File: rtl/stream_demux_8bit.sv
// Registered 1-to-2 byte-stream demultiplexer with valid/ready on input and both outputs.
// Define DEMUX_PKT_LOCK_EN to lock the route for PKT_LEN bytes from the first byte of a packet.
module stream_demux_8bit #(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] out0_data,
  output logic            out0_valid,
  input  logic            out0_ready,
  output logic [SIZE-1:0] out1_data,
  output logic            out1_valid,
  input  logic            out1_ready,
  output logic            busy
);

  logic            target;
  logic            accept;
  logic            load0;
  logic            load1;
  logic [SIZE-1:0] out0_data_q, out0_data_d;
  logic [SIZE-1:0] out1_data_q, out1_data_d;
  logic            out0_valid_q, out0_valid_d;
  logic            out1_valid_q, out1_valid_d;

  // Only the target output gates input, so a stalled non-target never blocks.
  assign in_ready = target ? (!out1_valid_q || out1_ready) : (!out0_valid_q || out0_ready);
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !target;
  assign load1    = accept && target;

  always_comb begin
    out0_valid_d = out0_valid_q;
    out0_data_d  = out0_data_q;
    out1_valid_d = out1_valid_q;
    out1_data_d  = out1_data_q;
    if (out0_valid_q && out0_ready) out0_valid_d = 1'b0;
    if (out1_valid_q && out1_ready) out1_valid_d = 1'b0;
    if (load0) begin
      out0_valid_d = 1'b1;
      out0_data_d  = in_data;
    end
    if (load1) begin
      out1_valid_d = 1'b1;
      out1_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out1_valid_q <= 1'b0;
      out1_data_q  <= '0;
    end else begin
      out0_valid_q <= out0_valid_d;
      out0_data_q  <= out0_data_d;
      out1_valid_q <= out1_valid_d;
      out1_data_q  <= out1_data_d;
    end
  end

  assign out0_data  = out0_data_q;
  assign out0_valid = out0_valid_q;
  assign out1_data  = out1_data_q;
  assign out1_valid = out1_valid_q;

`ifdef DEMUX_PKT_LOCK_EN
  typedef enum logic {StIdle, StLock} state_e;

  localparam logic [3:0] LastCnt = 4'(PKT_LEN - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cur_sel_q, cur_sel_d;

  assign target = (state_q == StLock) ? cur_sel_q : in_sel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      StIdle: begin
        // Single-byte packets never need a locked route.
        if (accept && (PKT_LEN != 1)) begin
          cur_sel_d = in_sel;
          cnt_d     = 4'd1;
          state_d   = StLock;
        end
      end
      StLock: begin
        if (accept) begin
          if (cnt_q == LastCnt) begin
            cnt_d   = 4'd0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      cur_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  assign busy = (state_q == StLock);
`else
  logic unused_pkt_len;

  assign target         = in_sel;
  assign busy           = 1'b0;
  assign unused_pkt_len = ^PKT_LEN;
`endif

endmodule

// File: tb/tb_stream_demux_8bit.sv
// Directed, table-driven bench for stream_demux_8bit; expectations adapt to DEMUX_PKT_LOCK_EN.
module tb_stream_demux_8bit;

`ifdef DEMUX_PKT_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  stream_demux_8bit #(
    .SIZE   (8),
    .PKT_LEN(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       s;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       ir;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       bz;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic r0,
                       input logic r1);
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic       exp_sel;
  logic [7:0] b;

  initial begin
    // Table: inputs held over one edge, in_ready checked before it, outputs after it.
    tv[0]  = '{H, L, 8'hA5, H, H, H, H, 8'hA5, L, 8'h00, H};
    tv[1]  = '{H, L, 8'hA6, H, H, H, H, 8'hA6, L, 8'h00, H};
    tv[2]  = '{L, L, 8'hFF, L, H, L, H, 8'hA6, L, 8'h00, H};
    tv[3]  = '{H, L, 8'hA7, L, H, L, H, 8'hA6, L, 8'h00, H};
    tv[4]  = '{H, L, 8'hA7, H, H, H, H, 8'hA7, L, 8'h00, H};
    tv[5]  = '{H, L, 8'hA8, H, H, H, H, 8'hA8, L, 8'h00, L};
    tv[6]  = '{L, L, 8'h00, H, H, H, L, 8'hA8, L, 8'h00, L};
    tv[7]  = '{H, H, 8'h22, H, L, H, L, 8'hA8, H, 8'h22, H};
    tv[8]  = '{H, H, 8'h23, H, L, L, L, 8'hA8, H, 8'h22, H};
    tv[9]  = '{H, H, 8'h23, H, H, H, L, 8'hA8, H, 8'h23, H};
    tv[10] = '{H, H, 8'h24, H, H, H, L, 8'hA8, H, 8'h24, H};
    tv[11] = '{H, H, 8'h25, H, H, H, L, 8'hA8, H, 8'h25, L};
    tv[12] = '{L, H, 8'h00, H, L, L, L, 8'hA8, H, 8'h25, L};
    tv[13] = '{H, L, 8'h33, H, L, H, H, 8'h33, H, 8'h25, H};
    tv[14] = '{H, L, 8'h34, H, L, H, H, 8'h34, H, 8'h25, H};
    tv[15] = '{H, L, 8'h35, H, L, H, H, 8'h35, H, 8'h25, H};
    tv[16] = '{H, L, 8'h36, H, L, H, H, 8'h36, H, 8'h25, L};
    tv[17] = '{L, L, 8'h00, H, H, H, L, 8'h36, L, 8'h25, L};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = 8'h00;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #12;
    chk("rst_v0", {7'd0, out0_valid}, 8'd0);
    chk("rst_v1", {7'd0, out1_valid}, 8'd0);
    chk("rst_d0", out0_data, 8'h00);
    chk("rst_d1", out1_data, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].v, tv[i].s, tv[i].d, tv[i].r0, tv[i].r1);
      chk($sformatf("tv%0d_in_ready", i), {7'd0, in_ready}, {7'd0, tv[i].ir});
      step();
      chk($sformatf("tv%0d_v0", i), {7'd0, out0_valid}, {7'd0, tv[i].v0});
      chk($sformatf("tv%0d_d0", i), out0_data, tv[i].d0);
      chk($sformatf("tv%0d_v1", i), {7'd0, out1_valid}, {7'd0, tv[i].v1});
      chk($sformatf("tv%0d_d1", i), out1_data, tv[i].d1);
      chk($sformatf("tv%0d_busy", i), {7'd0, busy}, {7'd0, tv[i].bz & LockEn});
    end

    // Packet lock: first byte picks out1, later in_sel=0 is ignored while locked.
    for (int i = 0; i < 5; i++) begin
      b = 8'h10 + 8'(i);
      drive(H, (i == 0), b, H, H);
      exp_sel = (i == 0) || (LockEn && i < 4);
      step();
      if (exp_sel) chk($sformatf("lock%0d_d1", i), out1_data, b);
      else chk($sformatf("lock%0d_d0", i), out0_data, b);
      chk($sformatf("lock%0d_busy", i), {7'd0, busy}, {7'd0, LockEn && (i != 3)});
    end

    // Streaming: 8 back-to-back bytes to out0, no bubbles.
    for (int i = 0; i < 8; i++) begin
      b = 8'h40 + 8'(i);
      drive(H, L, b, H, H);
      chk($sformatf("strm%0d_in_ready", i), {7'd0, in_ready}, 8'd1);
      step();
      chk($sformatf("strm%0d_d0", i), out0_data, b);
      chk($sformatf("strm%0d_v0", i), {7'd0, out0_valid}, 8'd1);
    end

    // Reset mid-packet with both outputs holding bytes.
    drive(L, L, 8'h00, H, H);
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(H, H, 8'h50 + 8'(i), H, H);
      step();
    end
    chk("fill_d1", out1_data, 8'h53);
    drive(H, L, 8'h66, L, L);
    chk("fill_in_ready", {7'd0, in_ready}, 8'd1);
    step();
    drive(H, L, 8'h67, H, L);
    step();
    drive(L, L, 8'h00, L, L);
    step();
    chk("pre_v0", {7'd0, out0_valid}, 8'd1);
    chk("pre_d0", out0_data, 8'h67);
    chk("pre_v1", {7'd0, out1_valid}, 8'd1);
    chk("pre_d1", out1_data, 8'h53);
    chk("pre_busy", {7'd0, busy}, {7'd0, LockEn});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v0", {7'd0, out0_valid}, 8'd0);
    chk("mid_rst_v1", {7'd0, out1_valid}, 8'd0);
    chk("mid_rst_d0", out0_data, 8'h00);
    chk("mid_rst_d1", out1_data, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_in_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(H, L, 8'h88, H, H);
    step();
    chk("post_d0", out0_data, 8'h88);
    chk("post_v1", {7'd0, out1_valid}, 8'd0);
    chk("post_busy", {7'd0, busy}, {7'd0, LockEn});
    drive(H, H, 8'h89, H, H);
    step();
    if (LockEn) chk("post2_d0", out0_data, 8'h89);
    else chk("post2_d1", out1_data, 8'h89);

    drive(L, L, 8'h00, H, H);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
